// File: rtl/ex1_1_mac3.sv
// ex1_1_mac3: sliding-window a*b+c producer over a valid/data sample stream.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_     in   asynchronous active-low reset, synchronous release
//   validi   in   data_in valid this cycle
//   data_in  in   [DW-1:0] input sample
//   clr      in   synchronous clear of out_cnt (wins over an increment)
//   valido   out  data_out holds a fresh result this cycle
//   data_out out  [DW-1:0] s2*s1 + data_in, truncated; holds between results
//   out_cnt  out  [CW-1:0] saturating count of valido pulses
module ex1_1_mac3 #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          validi,
    input  logic [DW-1:0] data_in,
    input  logic          clr,
    output logic          valido,
    output logic [DW-1:0] data_out,
    output logic [CW-1:0] out_cnt
);
    typedef enum logic [1:0] {IDLE, ONE, TWO, RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_s1;
    logic [DW-1:0]   r_s2;
    logic            w_fire;
    logic [2*DW-1:0] w_sum;

    always_comb begin
        w_next = IDLE;
        if (validi)
            w_next = (r_state == IDLE) ? ONE : (r_state == ONE) ? TWO : RUN;
        w_fire = validi && (r_state == TWO || r_state == RUN);
        // Full-width product plus zero-extended sample; only the low DW bits are kept.
        w_sum  = {{DW{1'b0}}, r_s2} * {{DW{1'b0}}, r_s1} + {{DW{1'b0}}, data_in};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= IDLE;
            r_s1     <= '0;
            r_s2     <= '0;
            valido   <= 1'b0;
            data_out <= '0;
            out_cnt  <= '0;
        end else begin
            r_state <= w_next;
            valido  <= w_fire;
            if (validi) begin
                r_s2 <= r_s1;
                r_s1 <= data_in;
            end
            if (w_fire)
                data_out <= w_sum[DW-1:0];
            out_cnt <= clr ? '0 : (w_fire && out_cnt != '1) ? out_cnt + CW'(1) : out_cnt;
        end
    end
endmodule

// File: tb/tb_ex1_1_mac3.sv
// tb_ex1_1_mac3: table-driven and directed checks for ex1_1_mac3 (default and CW=2 instances).
module tb_ex1_1_mac3;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        validi = 1'b0;
    logic [31:0] data_in = '0;
    logic        clr = 1'b0;
    logic        valido, valido2;
    logic [31:0] data_out, data_out2;
    logic [15:0] out_cnt;
    logic [1:0]  out_cnt2;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vt[$];

    ex1_1_mac3 u_dut (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .clr(clr),
        .valido(valido), .data_out(data_out), .out_cnt(out_cnt)
    );

    ex1_1_mac3 #(.DW(32), .CW(2)) u_cnt (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .clr(clr),
        .valido(valido2), .data_out(data_out2), .out_cnt(out_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic c);
        @(negedge clk);
        validi  = v;
        data_in = d;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic c,
                       input logic ev, input logic [31:0] ed, input logic [15:0] ec);
        vec_t e;
        e.v = v; e.d = d; e.c = c; e.ev = ev; e.ed = ed; e.ec = ec;
        vt.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valido"}, 64'(valido), 64'(0));
        chk({tag, " data_out"}, 64'(data_out), 64'(0));
        chk({tag, " out_cnt"}, 64'(out_cnt), 64'(0));
        chk({tag, " out_cnt2"}, 64'(out_cnt2), 64'(0));
    endtask

    initial begin
        // Gap breaks the run: data_out stays at its reset value
        add(1, 7, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0, 0);
        add(0, 7, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0, 0);
        add(0, 7, 0, 0, 0, 0);
        add(1, 7, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // Basic 2,3,4
        add(1, 2, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 0);
        add(1, 4, 0, 1, 10, 1);
        add(0, 0, 0, 0, 10, 1);
        add(0, 0, 0, 0, 10, 1);
        // Sliding window 2..6 after a clear
        add(0, 0, 1, 0, 10, 0);
        add(1, 2, 0, 0, 10, 0);
        add(1, 3, 0, 0, 10, 0);
        add(1, 4, 0, 1, 10, 1);
        add(1, 5, 0, 1, 17, 2);
        add(1, 6, 0, 1, 26, 3);
        add(0, 0, 0, 0, 26, 3);
        // Wrap-around
        add(1, 32'hFFFF_FFFF, 0, 0, 26, 3);
        add(1, 2, 0, 0, 26, 3);
        add(1, 1, 0, 1, 32'hFFFF_FFFF, 4);
        add(0, 0, 0, 0, 32'hFFFF_FFFF, 4);
        add(1, 32'h1_0000, 0, 0, 32'hFFFF_FFFF, 4);
        add(1, 32'h1_0000, 0, 0, 32'hFFFF_FFFF, 4);
        add(1, 5, 0, 1, 5, 5);
        add(0, 0, 0, 0, 5, 5);

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            validi  = 1'($urandom);
            data_in = $urandom;
            @(posedge clk);
            #1;
            chk_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        validi = 1'b0;
        rst_   = 1'b1;

        foreach (vt[i]) begin
            cyc(vt[i].v, vt[i].d, vt[i].c);
            chk($sformatf("vec%0d valido", i), 64'(valido), 64'(vt[i].ev));
            chk($sformatf("vec%0d data_out", i), 64'(data_out), 64'(vt[i].ed));
            chk($sformatf("vec%0d out_cnt", i), 64'(out_cnt), 64'(vt[i].ec));
            chk($sformatf("vec%0d out_cnt2", i), 64'(out_cnt2), 64'(vt[i].ec > 3 ? 3 : vt[i].ec));
        end

        // Reset asserted mid-run, applied without waiting for a clock edge
        cyc(1, 2, 0);
        cyc(1, 3, 0);
        cyc(1, 4, 0);
        chk("prerst valido", 64'(valido), 64'(1));
        chk("prerst data_out", 64'(data_out), 64'(10));
        #2;
        rst_ = 1'b0;
        #1;
        chk_zero("async_rst");
        cyc(1, 9, 0);
        chk_zero("rst_hold0");
        cyc(1, 9, 0);
        chk_zero("rst_hold1");
        @(negedge clk);
        rst_    = 1'b1;
        validi  = 1'b1;
        data_in = 5;
        @(posedge clk);
        #1;
        chk("post_rst1 valido", 64'(valido), 64'(0));
        cyc(1, 6, 0);
        chk("post_rst2 valido", 64'(valido), 64'(0));
        cyc(1, 7, 0);
        chk("post_rst3 valido", 64'(valido), 64'(1));
        chk("post_rst3 data_out", 64'(data_out), 64'(37));
        chk("post_rst3 out_cnt", 64'(out_cnt), 64'(1));

        // Saturating counter on the CW=2 instance
        cyc(0, 0, 1);
        chk("cnt_clr out_cnt2", 64'(out_cnt2), 64'(0));
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 0);
            chk($sformatf("sat%0d out_cnt2", i), 64'(out_cnt2), 64'(i < 2 ? 0 : (i - 1 > 3 ? 3 : i - 1)));
        end
        chk("sat valido2", 64'(valido2), 64'(1));
        chk("sat data_out2", 64'(data_out2), 64'(2));
        chk("sat main out_cnt", 64'(out_cnt), 64'(5));
        cyc(1, 1, 1);
        chk("clr_prio valido2", 64'(valido2), 64'(1));
        chk("clr_prio out_cnt2", 64'(out_cnt2), 64'(0));
        chk("clr_prio out_cnt", 64'(out_cnt), 64'(0));
        cyc(0, 0, 0);
        chk("clr_after valido", 64'(valido), 64'(0));
        chk("clr_after out_cnt2", 64'(out_cnt2), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
